// File: rtl/pool_engine_pkg.sv
// Shared definitions for the pooling engine: FSM states, width helpers and per-unit settings.
// Average pooling is compiled in only when POOL_AVG_EN is defined.
package pkg_pooling;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } pool_state_e;

  // Window sums of KER_SIZE^2 activations need 2*log2(KER_SIZE) extra bits.
  function automatic int unsigned acc_bits(input int unsigned act_bits, input int unsigned ker_size);
    return act_bits + 2 * $clog2(ker_size);
  endfunction

  function automatic int unsigned out_size(input int unsigned pool_size, input int unsigned ker_size);
    return pool_size / ker_size;
  endfunction

  localparam int unsigned N_UNITS = 2;
  localparam int unsigned UNIT_POOL_SIZE [N_UNITS] = '{14, 4};
  localparam int unsigned UNIT_KER_SIZE  [N_UNITS] = '{2, 2};
  localparam bit          UNIT_MAX_N_AVG [N_UNITS] = '{1'b1, 1'b0};
  localparam int unsigned UNIT_LANES     [N_UNITS] = '{2, 1};

endpackage

// File: rtl/pool_engine_lane.sv
// One lane of the pooling engine: line-buffer slice plus the max/add combine step.
// The adder path exists only when POOL_AVG_EN is defined.
module pool_lane
  import pkg_pooling::*;
#(
  parameter int unsigned ACT_BITS = 3,
  parameter int unsigned LB_BITS  = 3,
  parameter int unsigned SHIFT    = 0,
  parameter int unsigned OUT_SIZE = 7,
  parameter int unsigned IDX_W    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                first,
  input  logic                mode_max,
  input  logic [IDX_W-1:0]    idx,
  input  logic [ACT_BITS-1:0] act,
  output logic [ACT_BITS-1:0] result
);

  logic [LB_BITS-1:0] line_q [OUT_SIZE];
  logic [LB_BITS-1:0] prev;
  logic [LB_BITS-1:0] act_w;
  logic [LB_BITS-1:0] comb;
  logic [LB_BITS-1:0] shifted;

  // A zero base makes the first input of a window an overwrite for both max and add.
  assign prev  = first ? '0 : line_q[idx];
  assign act_w = LB_BITS'(act);

`ifdef POOL_AVG_EN
  always_comb begin
    comb = '0;
    if (mode_max) comb = (act_w > prev) ? act_w : prev;
    else          comb = prev + act_w;
  end
`else
  always_comb begin
    comb = '0;
    comb = (act_w > prev) ? act_w : prev;
  end
`endif

  assign shifted = comb >> SHIFT;
  assign result  = mode_max ? comb[ACT_BITS-1:0] : shifted[ACT_BITS-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < OUT_SIZE; i++) line_q[i] <= '0;
    end else if (en) begin
      line_q[idx] <= comb;
    end
  end

endmodule

// File: rtl/pool_engine.sv
// Streaming KxK/stride-K pooling over a POOL_SIZE^2 raster, LANES channels in parallel.
// Define POOL_AVG_EN to enable average pooling selected by mode_max; otherwise max only.
module pool_engine
  import pkg_pooling::*;
#(
  parameter int unsigned ACT_BITS  = 3,
  parameter int unsigned KER_SIZE  = 2,
  parameter int unsigned POOL_SIZE = 14,
  parameter int unsigned LANES     = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      mode_max,
  output logic                      busy,
  output logic                      done,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*ACT_BITS-1:0] in_act,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*ACT_BITS-1:0] out_act
);

  localparam int unsigned OUT_SIZE = out_size(POOL_SIZE, KER_SIZE);
  localparam int unsigned CW       = $clog2(POOL_SIZE);
  localparam int unsigned LOG2K    = $clog2(KER_SIZE);
  localparam int unsigned IDX_W    = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
`ifdef POOL_AVG_EN
  localparam int unsigned LB_BITS  = acc_bits(ACT_BITS, KER_SIZE);
  localparam int unsigned SHIFT    = 2 * LOG2K;
`else
  localparam int unsigned LB_BITS  = ACT_BITS;
  localparam int unsigned SHIFT    = 0;
`endif
  localparam logic [CW-1:0] LAST  = CW'(POOL_SIZE - 1);
  localparam logic [CW-1:0] KMASK = CW'(KER_SIZE - 1);
  localparam logic [CW:0]   LIMIT = (CW+1)'(OUT_SIZE * KER_SIZE);

  pool_state_e             state_q;
  logic [CW-1:0]           col_q, row_q;
  logic                    mode_q, mode_eff;
  logic                    xfer, in_win, win_first, win_last;
  logic [IDX_W-1:0]        entry;
  logic [LANES*ACT_BITS-1:0] lane_res;

`ifdef POOL_AVG_EN
  assign mode_eff = mode_q;
`else
  logic unused_mode;
  assign unused_mode = mode_q;
  assign mode_eff    = 1'b1;
`endif

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DRAIN) && !out_valid;
  assign in_ready  = (state_q == ST_RUN) && !(out_valid && !out_ready);
  assign xfer      = in_valid && in_ready;
  // Trailing rows/columns beyond OUT_SIZE*KER_SIZE are consumed but never pooled.
  assign in_win    = ({1'b0, col_q} < LIMIT) && ({1'b0, row_q} < LIMIT);
  assign win_first = ((col_q & KMASK) == '0)    && ((row_q & KMASK) == '0);
  assign win_last  = ((col_q & KMASK) == KMASK) && ((row_q & KMASK) == KMASK);
  assign entry     = IDX_W'(col_q >> LOG2K);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    pool_lane #(
      .ACT_BITS (ACT_BITS),
      .LB_BITS  (LB_BITS),
      .SHIFT    (SHIFT),
      .OUT_SIZE (OUT_SIZE),
      .IDX_W    (IDX_W)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (xfer && in_win),
      .first    (win_first),
      .mode_max (mode_eff),
      .idx      (entry),
      .act      (in_act[g*ACT_BITS +: ACT_BITS]),
      .result   (lane_res[g*ACT_BITS +: ACT_BITS])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
      out_act   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          state_q <= ST_RUN;
          col_q   <= '0;
          row_q   <= '0;
          mode_q  <= mode_max;
        end
        ST_RUN:   if (xfer && col_q == LAST && row_q == LAST) state_q <= ST_DRAIN;
        ST_DRAIN: if (!out_valid) state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase

      if (xfer) begin
        if (col_q == LAST) begin
          col_q <= '0;
          row_q <= (row_q == LAST) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end

      // A load wins over the drain; in_ready guarantees the register is free or leaving.
      if (xfer && in_win && win_last) begin
        out_act   <= lane_res;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pool_engine.sv
// Self-checking bench for pool_engine (P=5, K=2, 2 lanes) against a window-arithmetic model.
module tb_pool_engine;

  localparam int unsigned AB   = 3;
  localparam int unsigned KS   = 2;
  localparam int unsigned PS   = 5;
  localparam int unsigned LN   = 2;
  localparam int unsigned OS   = PS / KS;
  localparam int unsigned NPIX = PS * PS;
  localparam int          BUDGET = 2000;
`ifdef POOL_AVG_EN
  localparam bit AVG_EN = 1'b1;
`else
  localparam bit AVG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic mode_max = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [LN*AB-1:0] in_act = '0;
  logic busy, done, in_ready, out_valid;
  logic [LN*AB-1:0] out_act;

  int total = 0;
  int bad = 0;

  logic [AB-1:0] pix [LN][NPIX];
  logic [LN*AB-1:0] exp_q [$];
  int n_in, n_out, n_done;

  pool_engine #(
    .ACT_BITS  (AB),
    .KER_SIZE  (KS),
    .POOL_SIZE (PS),
    .LANES     (LN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode_max  (mode_max),
    .busy      (busy),
    .done      (done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_act    (in_act),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_act   (out_act)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Pooled value of one output position, straight from the window definition.
  function automatic logic [LN*AB-1:0] ref_out(input int oy, input int ox, input bit use_max);
    logic [LN*AB-1:0] r;
    r = '0;
    for (int l = 0; l < LN; l++) begin
      int acc, mx, v;
      acc = 0;
      mx  = 0;
      for (int dy = 0; dy < KS; dy++)
        for (int dx = 0; dx < KS; dx++) begin
          v = int'(pix[l][(KS*oy + dy)*PS + KS*ox + dx]);
          acc += v;
          if (v > mx) mx = v;
        end
      r[l*AB +: AB] = AB'(use_max ? mx : acc / (KS*KS));
    end
    return r;
  endfunction

  task automatic gen_frame(input int pat);
    for (int l = 0; l < LN; l++)
      for (int i = 0; i < NPIX; i++) begin
        int r, c;
        r = i / PS;
        c = i % PS;
        case (pat)
          1: pix[l][i] = AB'((i + 3*l) % 8);
          2: if (r < KS*OS && c < KS*OS)
               pix[l][i] = (((r%2)*2 + c%2) == ((l + r/2 + c/2) % 4)) ? AB'(0) : AB'(7);
             else
               pix[l][i] = AB'($urandom);
          default: pix[l][i] = AB'($urandom);
        endcase
      end
  endtask

  task automatic apply_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    start     = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_act", out_act, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_frame(input bit mm, input int pat, input bit rnd, input bit stall, input int abort_at);
    int cyc, busy_low, stall_viol, hold_viol, stall_left, extra_done;
    bit stall_done, prev_hold;
    logic [LN*AB-1:0] prev_act, exp_v;
    cyc = 0; busy_low = 0; stall_viol = 0; hold_viol = 0; stall_left = 0; extra_done = 0;
    stall_done = 1'b0; prev_hold = 1'b0; prev_act = '0;
    gen_frame(pat);
    exp_q.delete();
    for (int oy = 0; oy < OS; oy++)
      for (int ox = 0; ox < OS; ox++)
        exp_q.push_back(ref_out(oy, ox, mm || !AVG_EN));
    n_in = 0; n_out = 0; n_done = 0;

    mode_max = mm;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("busy_after_start", busy, 1);

    while (n_done == 0 && cyc < BUDGET) begin
      in_valid = (n_in < NPIX) && (!rnd || $urandom_range(0, 3) != 0);
      for (int l = 0; l < LN; l++)
        in_act[l*AB +: AB] = pix[l][(n_in < NPIX) ? n_in : 0];
      if (stall && !stall_done && out_valid) begin
        stall_left = 10;
        stall_done = 1'b1;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = !rnd || ($urandom_range(0, 2) != 0);
      end
      start    = (cyc == 3);
      mode_max = 1'($urandom_range(0, 1));
      #1;
      if (!busy) busy_low++;
      if (out_valid && !out_ready && in_ready) stall_viol++;
      if (prev_hold && (!out_valid || out_act !== prev_act)) hold_viol++;
      prev_hold = out_valid && !out_ready;
      prev_act  = out_act;
      if (out_valid && out_ready) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check("out_act", 32'(out_act), 32'(exp_v));
        n_out++;
      end
      if (in_valid && in_ready) n_in++;
      if (done) n_done++;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (abort_at > 0 && n_in >= abort_at) break;
    end
    start = 1'b0;

    if (abort_at > 0) begin
      check("abort_inputs", n_in, abort_at);
      check("abort_no_done", n_done, 0);
      apply_reset();
      return;
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("frame_timeout", 32'(cyc < BUDGET), 1);
    check("done_count", n_done, 1);
    check("inputs_at_done", n_in, NPIX);
    check("output_count", n_out, OS*OS);
    check("outputs_left", exp_q.size(), 0);
    check("busy_in_frame", busy_low, 0);
    check("in_ready_stall", stall_viol, 0);
    check("out_hold", hold_viol, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      if (done) extra_done++;
      @(negedge clk);
    end
    check("done_once", extra_done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    apply_reset();
    run_frame(1'b1, 1, 1'b0, 1'b0, 0);
    run_frame(1'b1, 0, 1'b1, 1'b0, 0);
    run_frame(1'b0, 2, 1'b0, 1'b0, 0);
    run_frame(1'b0, 0, 1'b0, 1'b1, 0);
    run_frame(1'b1, 0, 1'b1, 1'b0, 6);
    run_frame(1'b1, 1, 1'b1, 1'b0, 0);
    for (int f = 0; f < 6; f++)
      run_frame(1'($urandom_range(0, 1)), 0, 1'b1, f[0], 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
